// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment bit positions, hex glyph table
// (gfedcba, active-high form) and the nibble decode helper.
package seven_seg_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Entry 15 first so that SEG_LUT[v] selects the glyph for nibble v.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        return SEG_LUT[value];
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to seven-segment decoder (active-high segments),
// with a blank input that forces every segment dark.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = '0;
        if (!blank) begin
            seg = seg_decode(value);
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with per-frame input
// snapshot, blanking, blinking, leading-zero suppression and anti-ghost gaps.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLANK_CYC      = 2,
    parameter int unsigned BLINK_DIV      = 64,
    parameter int unsigned ACTIVE_LOW_SEG = 1,
    parameter int unsigned ACTIVE_LOW_SEL = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   sel,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM  = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = (ACTIVE_LOW_SEG != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW_SEL != 0) ? '1 : '0;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    blink_phase;
    logic [BW-1:0]           blink_cnt;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp, snap_blank, snap_blink;
    logic                    snap_lz;

    logic                    capture, last_slot, frame_end, dark;
    logic [4*NUM_DIGITS-1:0] cur_digits;
    logic [NUM_DIGITS-1:0]   cur_dp, cur_blank, cur_blink, lz_dark;
    logic                    cur_lz;
    logic [3:0]              cur_val;
    logic [6:0]              seg_raw, seg_drive;
    logic                    dp_drive;
    logic [NUM_DIGITS-1:0]   sel_hot, sel_drive;

    // The capture cycle decodes straight from the inputs so the first slot
    // already sees the new frame's values even when BLANK_CYC is 0.
    always_comb begin
        capture    = (idx == '0) && (cnt == '0);
        last_slot  = (cnt == CNT_LAST);
        frame_end  = last_slot && (idx == IDX_LAST);
        cur_digits = capture ? digits_in   : snap_digits;
        cur_dp     = capture ? dp_in       : snap_dp;
        cur_blank  = capture ? blank_mask  : snap_blank;
        cur_blink  = capture ? blink_mask  : snap_blink;
        cur_lz     = capture ? lz_suppress : snap_lz;
    end

    always_comb begin
        logic nz_seen;
        lz_dark = '0;
        nz_seen = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (cur_digits[4*(NUM_DIGITS-1-i) +: 4] != 4'h0) begin
                nz_seen = 1'b1;
            end
            if (cur_lz && !nz_seen && (i != NUM_DIGITS - 1)) begin
                lz_dark[NUM_DIGITS-1-i] = 1'b1;
            end
        end
    end

    always_comb begin
        cur_val = cur_digits[int'(idx)*4 +: 4];
        dark    = cur_blank[idx] | (blink_phase & cur_blink[idx]) | lz_dark[idx];
    end

    seven_seg_decode u_decode (
        .value (cur_val),
        .blank (dark),
        .seg   (seg_raw)
    );

    always_comb begin
        sel_hot   = NUM_DIGITS'(1) << idx;
        sel_drive = (ACTIVE_LOW_SEL != 0) ? ~sel_hot : sel_hot;
        seg_drive = (ACTIVE_LOW_SEG != 0) ? ~seg_raw : seg_raw;
        dp_drive  = (cur_dp[idx] & ~dark) ^ DP_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg         <= SEG_OFF;
            dp          <= DP_OFF;
            sel         <= SEL_OFF;
            frame_done  <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
        end else if (!en) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            sel        <= SEL_OFF;
            frame_done <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
        end else begin
            if (capture) begin
                snap_digits <= digits_in;
                snap_dp     <= dp_in;
                snap_blank  <= blank_mask;
                snap_blink  <= blink_mask;
                snap_lz     <= lz_suppress;
            end
            frame_done <= frame_end;
            if (cnt < BLANK_LIM) begin
                seg <= SEG_OFF;
                dp  <= DP_OFF;
                sel <= SEL_OFF;
            end else begin
                seg <= seg_drive;
                dp  <= dp_drive;
                sel <= sel_drive;
            end
            if (last_slot) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver: directed steps plus a random
// phase, compared against a frame-position reference model.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BD    = 2;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst, en, lz_suppress;
    logic [15:0] digits_in;
    logic [3:0]  dp_in, blank_mask, blink_mask;
    logic [6:0]  seg;
    logic        dp, frame_done;
    logic [3:0]  sel;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SD),
        .BLANK_CYC      (BC),
        .BLINK_DIV      (BD),
        .ACTIVE_LOW_SEG (1),
        .ACTIVE_LOW_SEL (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .sel         (sel),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks   = 0;
    int failures = 0;
    int fd_seen  = 0;

    // Model: position within the current frame and completed-frame count.
    int          pos    = 0;
    int          frames = 0;
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_blank, m_blink;
    logic        m_lz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h pos=%0d", tag, obs, exp, pos);
        end
    endtask

    task automatic tick();
        logic [6:0] e_seg;
        logic [3:0] e_sel;
        logic       e_dp, e_fd, dark, allz;
        int         slot, sub, val;
        e_seg = 7'h7F;
        e_sel = 4'hF;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
        if (rst) begin
            pos = 0; frames = 0;
            m_digits = '0; m_dp = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0;
        end else if (!en) begin
            pos = 0;
        end else begin
            if (pos == 0) begin
                m_digits = digits_in; m_dp = dp_in; m_blank = blank_mask;
                m_blink = blink_mask; m_lz = lz_suppress;
            end
            slot = pos / SD;
            sub  = pos % SD;
            e_fd = (pos == FRAME - 1);
            if (sub >= BC) begin
                val  = int'((m_digits >> (4 * slot)) & 16'hF);
                allz = 1'b1;
                for (int j = slot; j < ND; j++)
                    if (((m_digits >> (4 * j)) & 16'hF) != 16'h0) allz = 1'b0;
                dark = m_blank[slot] || ((((frames / BD) % 2) == 1) && m_blink[slot])
                       || (m_lz && slot != 0 && allz);
                e_sel = ~(4'b0001 << slot);
                e_seg = dark ? 7'h7F : ~hex_tab[val];
                e_dp  = dark ? 1'b1 : ~m_dp[slot];
            end
            pos = (pos + 1) % FRAME;
            if (e_fd) frames++;
        end
        @(posedge clk);
        #1;
        chk("seg", {25'd0, seg}, {25'd0, e_seg});
        chk("sel", {28'd0, sel}, {28'd0, e_sel});
        chk("dp", {31'd0, dp}, {31'd0, e_dp});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
        if (frame_done) fd_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int p);
        for (int n = 0; n < FRAME && pos != p; n++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] sel_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] seg_exp [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

    initial begin
        rst = 1'b1; en = 1'b1; lz_suppress = 1'b0;
        digits_in = 16'h1234; dp_in = '0; blank_mask = '0; blink_mask = '0;

        // Reset with en high
        ticks(3);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_sel", {28'd0, sel}, 32'hF);
        chk("rst_dp", {31'd0, dp}, 32'h1);
        chk("rst_fd", {31'd0, frame_done}, 32'h0);

        // Scan 1234 for two frames; first lit select on the third cycle
        rst = 1'b0;
        fd_seen = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (i < 2) chk("pre_first_sel", {28'd0, sel}, 32'hF);
            if ((i % SD) == 2) begin
                chk("scan_sel", {28'd0, sel}, {28'd0, sel_exp[(i % FRAME) / SD]});
                chk("scan_seg", {25'd0, seg}, {25'd0, seg_exp[(i % FRAME) / SD]});
            end
        end
        chk("fd_count", fd_seen, 32'd2);

        // Leading-zero suppression
        digits_in = 16'h0070; lz_suppress = 1'b1; dp_in = 4'b0110;
        run_to(0);
        ticks(2 * FRAME);
        digits_in = 16'h0000;
        ticks(2 * FRAME);
        run_to(SD + 3);
        chk("lz_all_zero_d1", {25'd0, seg}, 32'h7F);
        run_to(3);
        chk("lz_all_zero_d0", {25'd0, seg}, 32'h40);

        // Blink then blank, from a fresh reset so frame numbering starts at 0
        digits_in = 16'h1234; lz_suppress = 1'b0; dp_in = 4'b0001; blink_mask = 4'b0001;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            run_to(3);
            chk("blink_d0", {25'd0, seg}, (f == 2 || f == 3) ? 32'h7F : 32'h19);
            run_to(0);
        end
        blink_mask = '0; blank_mask = 4'b1000;
        ticks(2 * FRAME);

        // Snapshot: change during digit 2's slot
        blank_mask = '0; digits_in = 16'h1234;
        do_reset();
        run_to(2 * SD + 3);
        digits_in = 16'h5678;
        run_to(3 * SD + 3);
        chk("snap_old_d3", {25'd0, seg}, 32'h79);
        tick();
        run_to(3 * SD + 3);
        chk("snap_new_d3", {25'd0, seg}, 32'h12);
        run_to(3);
        chk("snap_new_d0", {25'd0, seg}, 32'h00);

        // en drop mid-frame, then reset during digit 2
        blink_mask = 4'b1111;
        run_to(13);
        en = 1'b0;
        tick();
        chk("en_off_sel", {28'd0, sel}, 32'hF);
        ticks(3);
        en = 1'b1;
        ticks(FRAME + 5);
        run_to(2 * SD + 4);
        rst = 1'b1;
        tick();
        chk("rst_mid_sel", {28'd0, sel}, 32'hF);
        rst = 1'b0;
        ticks(2 * FRAME);

        // Random phase
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 4; k++)
                    digits_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                dp_in       = 4'($urandom);
                blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                blink_mask  = 4'($urandom);
                lz_suppress = 1'($urandom);
            end
            en  = ($urandom_range(0, 49) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
